// File: rtl/gen_lut_search_if.sv
// Requester/ROM-facing bus of the reverse-lookup engine: request, response and
// the combinational ROM address/data pair.
interface gen_lut_search_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int ROM_WIDTH  = 8
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [ROM_WIDTH-1:0]  key_i;
    logic [ADDR_WIDTH-1:0] rom_addr_o;
    logic [ROM_WIDTH-1:0]  rom_data_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic                  rsp_found_o;
    logic [ADDR_WIDTH-1:0] rsp_addr_o;

    modport slave (
        input  req_valid_i, key_i, rom_data_i, rsp_ready_i,
        output req_ready_o, rom_addr_o, rsp_valid_o, rsp_found_o, rsp_addr_o
    );

    modport master (
        output req_valid_i, key_i, rom_data_i, rsp_ready_i,
        input  req_ready_o, rom_addr_o, rsp_valid_o, rsp_found_o, rsp_addr_o
    );
endinterface

// File: rtl/gen_lut_search.sv
// Reverse lookup over a combinational-read LUT ROM: linear scan from address 0,
// reporting the lowest address whose word equals the key, or a miss.
module gen_lut_search #(
    parameter int ADDR_WIDTH = 10,
    parameter int ROM_WIDTH  = 8
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    gen_lut_search_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ROM_WIDTH-1:0]  r_key;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic                  r_found;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  w_match;
    logic                  w_last;

    assign w_match = (bus.rom_data_i == r_key);
    assign w_last  = &r_rom_addr;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid_i) w_state_next = SCAN;
            SCAN:    if (w_match || w_last) w_state_next = RESP;
            RESP:    if (bus.rsp_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= IDLE;
            r_key      <= '0;
            r_rom_addr <= '0;
            r_found    <= 1'b0;
            r_addr     <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        r_key      <= bus.key_i;
                        r_rom_addr <= '0;
                    end
                end
                SCAN: begin
                    // Match is checked before the terminal count so the last word can still hit.
                    if (w_match) begin
                        r_found <= 1'b1;
                        r_addr  <= r_rom_addr;
                    end else if (w_last) begin
                        r_found <= 1'b0;
                        r_addr  <= '0;
                    end else begin
                        r_rom_addr <= r_rom_addr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready_o = (r_state == IDLE);
    assign bus.rsp_valid_o = (r_state == RESP);
    assign bus.rom_addr_o  = r_rom_addr;
    assign bus.rsp_found_o = r_found;
    assign bus.rsp_addr_o  = r_addr;
endmodule
